// File: rtl/xor_parity_deframer.sv
// xor_parity_deframer: reassembles MSB-first serial frames plus a parity bit and flags parity errors
// Ports:
//   clk, rst                     clock and synchronous active-high reset
//   in_valid, in_ready, in_bit   serial bit input handshake
//   out_valid, out_ready         frame output handshake
//   out_data                     received frame, first bit in the MSB
//   out_parity_err               parity check failed for the presented frame
//   err_count                    saturating count of errored frames
module xor_parity_deframer #(
    parameter int FRAME_LEN  = 8,
    parameter bit ODD_PARITY = 1'b0,
    parameter int ERR_CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_bit,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [FRAME_LEN-1:0] out_data,
    output logic                 out_parity_err,
    output logic [ERR_CNT_W-1:0] err_count
);
    localparam int CW = FRAME_LEN > 1 ? $clog2(FRAME_LEN) : 1;
    localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);
    typedef enum logic [1:0] {RECV_DATA, RECV_PAR, OUT_HOLD} state_t;
    state_t                 state_q;
    logic [CW-1:0]          cnt_q;
    logic                   acc_q, acc_d, err_d, accept;
    logic [FRAME_LEN-1:0]   shift_q, shift_d;
    logic [FRAME_LEN:0]     shift_ext;
    assign in_ready  = (state_q != OUT_HOLD) && !rst;
    assign accept    = in_valid && in_ready;
    // Widened concatenation keeps the shift legal when FRAME_LEN is 1
    assign shift_ext = {shift_q, in_bit};
    assign shift_d   = shift_ext[FRAME_LEN-1:0];
    assign acc_d     = acc_q ^ in_bit;
    assign err_d     = acc_d != ODD_PARITY;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= RECV_DATA;
            cnt_q          <= '0;
            acc_q          <= 1'b0;
            shift_q        <= '0;
            out_valid      <= 1'b0;
            out_data       <= '0;
            out_parity_err <= 1'b0;
            err_count      <= '0;
        end else begin
            case (state_q)
                RECV_DATA: if (accept) begin
                    shift_q <= shift_d;
                    acc_q   <= acc_d;
                    cnt_q   <= cnt_q == LAST ? '0 : cnt_q + CW'(1);
                    state_q <= cnt_q == LAST ? RECV_PAR : RECV_DATA;
                end
                RECV_PAR: if (accept) begin
                    out_data       <= shift_q;
                    out_parity_err <= err_d;
                    out_valid      <= 1'b1;
                    if (err_d && !(&err_count)) err_count <= err_count + ERR_CNT_W'(1);
                    state_q        <= OUT_HOLD;
                end
                OUT_HOLD: if (out_ready) begin
                    out_valid <= 1'b0;
                    acc_q     <= 1'b0;
                    shift_q   <= '0;
                    state_q   <= RECV_DATA;
                end
                default: state_q <= RECV_DATA;
            endcase
        end
    end
endmodule

// File: tb/tb_xor_parity_deframer.sv
// tb_xor_parity_deframer: directed self-checking bench for three parameterisations of the deframer
module tb_xor_parity_deframer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   pass = 0;
    int   total = 0;
    always #5 clk = ~clk;

    logic       a_in_valid = 0, a_in_bit = 0, a_out_ready = 0;
    logic       a_in_ready, a_out_valid, a_out_parity_err;
    logic [7:0] a_out_data;
    logic [15:0] a_err_count;
    xor_parity_deframer u_a (
        .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_bit(a_in_bit),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .out_parity_err(a_out_parity_err), .err_count(a_err_count)
    );

    logic       b_in_valid = 0, b_in_bit = 0, b_out_ready = 1;
    logic       b_in_ready, b_out_valid, b_out_parity_err;
    logic [0:0] b_out_data;
    logic [1:0] b_err_count;
    xor_parity_deframer #(.FRAME_LEN(1), .ODD_PARITY(1'b1), .ERR_CNT_W(2)) u_b (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_bit(b_in_bit),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .out_parity_err(b_out_parity_err), .err_count(b_err_count)
    );

    logic       c_in_valid = 0, c_in_bit = 0, c_out_ready = 1;
    logic       c_in_ready, c_out_valid, c_out_parity_err;
    logic [3:0] c_out_data;
    logic [15:0] c_err_count;
    xor_parity_deframer #(.FRAME_LEN(4)) u_c (
        .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready), .in_bit(c_in_bit),
        .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
        .out_parity_err(c_out_parity_err), .err_count(c_err_count)
    );

    task automatic a_frame(input logic [7:0] d, input logic p);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            a_in_valid = 1'b1;
            a_in_bit   = i < 8 ? d[7-i] : p;
        end
        @(negedge clk);
        a_in_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (a_in_ready !== 1'b0) $display("FAIL reset_in_ready got %b want 0", a_in_ready); else pass++;
        total++; if (a_out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", a_out_valid); else pass++;
        total++; if (a_out_data !== 8'h00) $display("FAIL reset_out_data got %h want 00", a_out_data); else pass++;
        total++; if (a_out_parity_err !== 1'b0) $display("FAIL reset_parity_err got %b want 0", a_out_parity_err); else pass++;
        total++; if (a_err_count !== 16'd0) $display("FAIL reset_err_count got %0d want 0", a_err_count); else pass++;
        rst = 1'b0;
        @(negedge clk);
        total++; if (a_in_ready !== 1'b1) $display("FAIL post_reset_in_ready got %b want 1", a_in_ready); else pass++;
    endtask

    task automatic test_good_frame;
        a_out_ready = 1'b1;
        a_frame(8'hA5, 1'b0);
        total++; if (a_out_valid !== 1'b1) $display("FAIL good_valid got %b want 1", a_out_valid); else pass++;
        total++; if (a_out_data !== 8'hA5) $display("FAIL good_data got %h want a5", a_out_data); else pass++;
        total++; if (a_out_parity_err !== 1'b0) $display("FAIL good_err got %b want 0", a_out_parity_err); else pass++;
        total++; if (a_in_ready !== 1'b0) $display("FAIL good_hold_ready got %b want 0", a_in_ready); else pass++;
        @(negedge clk);
        total++; if (a_out_valid !== 1'b0) $display("FAIL good_valid_one_cycle got %b want 0", a_out_valid); else pass++;
        total++; if (a_err_count !== 16'd0) $display("FAIL good_err_count got %0d want 0", a_err_count); else pass++;
        total++; if (a_in_ready !== 1'b1) $display("FAIL good_ready_again got %b want 1", a_in_ready); else pass++;
    endtask

    task automatic test_parity_error;
        a_frame(8'h07, 1'b0);
        total++; if (a_out_parity_err !== 1'b1) $display("FAIL bad_err got %b want 1", a_out_parity_err); else pass++;
        total++; if (a_err_count !== 16'd1) $display("FAIL bad_err_count got %0d want 1", a_err_count); else pass++;
        total++; if (a_out_data !== 8'h07) $display("FAIL bad_data got %h want 07", a_out_data); else pass++;
        a_frame(8'h07, 1'b1);
        total++; if (a_out_valid !== 1'b1) $display("FAIL fixed_valid got %b want 1", a_out_valid); else pass++;
        total++; if (a_out_parity_err !== 1'b0) $display("FAIL fixed_err got %b want 0", a_out_parity_err); else pass++;
        total++; if (a_err_count !== 16'd1) $display("FAIL fixed_err_count got %0d want 1", a_err_count); else pass++;
    endtask

    task automatic test_backpressure;
        @(negedge clk);
        a_out_ready = 1'b0;
        a_frame(8'hA5, 1'b0);
        for (int i = 0; i < 5; i++) begin
            total++; if (a_in_ready !== 1'b0) $display("FAIL bp_ready[%0d] got %b want 0", i, a_in_ready); else pass++;
            total++; if (a_out_valid !== 1'b1) $display("FAIL bp_valid[%0d] got %b want 1", i, a_out_valid); else pass++;
            total++; if (a_out_data !== 8'hA5) $display("FAIL bp_data[%0d] got %h want a5", i, a_out_data); else pass++;
            a_in_valid = 1'b1;
            a_in_bit   = 1'($urandom);
            @(negedge clk);
        end
        a_in_valid  = 1'b0;
        a_out_ready = 1'b1;
        @(negedge clk);
        total++; if (a_out_valid !== 1'b0) $display("FAIL bp_release got %b want 0", a_out_valid); else pass++;
        a_frame(8'h3C, 1'b0);
        total++; if (a_out_data !== 8'h3C) $display("FAIL bp_next_data got %h want 3c", a_out_data); else pass++;
        total++; if (a_out_parity_err !== 1'b0) $display("FAIL bp_next_err got %b want 0", a_out_parity_err); else pass++;
        total++; if (a_err_count !== 16'd1) $display("FAIL bp_err_count got %0d want 1", a_err_count); else pass++;
    endtask

    task automatic test_reset_mid_frame;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            a_in_valid = 1'b1;
            a_in_bit   = 1'b1;
        end
        @(negedge clk);
        a_in_valid = 1'b0;
        rst        = 1'b1;
        #1;
        total++; if (a_in_ready !== 1'b0) $display("FAIL mid_rst_ready got %b want 0", a_in_ready); else pass++;
        @(negedge clk);
        rst = 1'b0;
        total++; if (a_err_count !== 16'd0) $display("FAIL mid_rst_err_count got %0d want 0", a_err_count); else pass++;
        a_frame(8'h3C, 1'b0);
        total++; if (a_out_valid !== 1'b1) $display("FAIL mid_rst_valid got %b want 1", a_out_valid); else pass++;
        total++; if (a_out_data !== 8'h3C) $display("FAIL mid_rst_data got %h want 3c", a_out_data); else pass++;
        total++; if (a_out_parity_err !== 1'b0) $display("FAIL mid_rst_err got %b want 0", a_out_parity_err); else pass++;
        total++; if (a_err_count !== 16'd0) $display("FAIL mid_rst_count got %0d want 0", a_err_count); else pass++;
    endtask

    task automatic test_saturation;
        logic [1:0] exp_cnt [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            b_in_valid = 1'b1;
            b_in_bit   = 1'b1;
            @(negedge clk);
            b_in_bit   = 1'b1;
            @(negedge clk);
            b_in_valid = 1'b0;
            total++; if (b_out_valid !== 1'b1) $display("FAIL sat_valid[%0d] got %b want 1", k, b_out_valid); else pass++;
            total++; if (b_out_data !== 1'b1) $display("FAIL sat_data[%0d] got %b want 1", k, b_out_data); else pass++;
            total++; if (b_out_parity_err !== 1'b1) $display("FAIL sat_err[%0d] got %b want 1", k, b_out_parity_err); else pass++;
            total++; if (b_err_count !== exp_cnt[k]) $display("FAIL sat_count[%0d] got %0d want %0d", k, b_err_count, exp_cnt[k]); else pass++;
        end
    endtask

    task automatic test_sparse;
        logic [4:0] bits = 5'b1011_1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            c_in_valid = 1'b1;
            c_in_bit   = bits[4-i];
            @(negedge clk);
            c_in_valid = 1'b0;
            c_in_bit   = ~bits[4-i];
        end
        total++; if (c_out_valid !== 1'b1) $display("FAIL sparse_valid got %b want 1", c_out_valid); else pass++;
        total++; if (c_out_data !== 4'hB) $display("FAIL sparse_data got %h want b", c_out_data); else pass++;
        total++; if (c_out_parity_err !== 1'b0) $display("FAIL sparse_err got %b want 0", c_out_parity_err); else pass++;
        @(negedge clk);
        total++; if (c_out_valid !== 1'b0) $display("FAIL sparse_valid_fall got %b want 0", c_out_valid); else pass++;
        total++; if (c_out_data !== 4'hB) $display("FAIL sparse_data_kept got %h want b", c_out_data); else pass++;
        total++; if (c_err_count !== 16'd0) $display("FAIL sparse_count got %0d want 0", c_err_count); else pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_good_frame();
        test_parity_error();
        test_backpressure();
        test_reset_mid_frame();
        test_saturation();
        test_sparse();
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule

// File: doc/xor_parity_deframer.md
Name: xor_parity_deframer

Overview:
- Serial receive stage downstream of the XOR gate primitive.
- Accepts a bit stream one bit per handshake and reassembles FRAME_LEN data bits, MSB first, followed by one parity bit.
- The running XOR of every received bit checks parity; each frame is presented on a valid/ready output port with an error flag.
- Keeps a saturating count of frames that failed the parity check.

Parameters:
- FRAME_LEN, 8, data bits per frame; legal range 1..64.
- ODD_PARITY, 0, 0 = even parity (XOR of data and parity bit must be 0); 1 = odd parity (XOR must be 1).
- ERR_CNT_W, 16, width of err_count.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_bit is valid this cycle.
- in_ready  output  1  block accepts in_bit this cycle.
- in_bit  input  1  serial data or parity bit.
- out_valid  output  1  out_data and out_parity_err hold a completed frame.
- out_ready  input  1  consumer accepts the frame.
- out_data  output  FRAME_LEN  received data; first received bit is the MSB.
- out_parity_err  output  1  1 = parity check failed for the presented frame.
- err_count  output  ERR_CNT_W  saturating count of frames with a parity error.

Behaviour:
- One clock domain, clk. Reset is synchronous and active-high on rst; every register updates only on the rising edge of clk.
- Reset values:
  - state RECV_DATA, bit counter 0, XOR accumulator 0, shift register 0.
  - out_valid 0, out_data 0, out_parity_err 0, err_count 0.
- in_ready = (state != OUT_HOLD) and not rst. It is combinational from registered state only, with no path from in_valid.
- An accept is in_valid and in_ready high in the same cycle. Bits offered while in_ready is low are ignored.
- State RECV_DATA, on accept:
  - shift register <= {shift[FRAME_LEN-2:0], in_bit}; for FRAME_LEN = 1 it loads in_bit.
  - acc <= acc ^ in_bit.
  - count <= count + 1.
  - If count == FRAME_LEN-1, count <= 0 and go to RECV_PAR.
- State RECV_PAR, on accept:
  - out_data <= shift register.
  - out_parity_err <= (acc ^ in_bit) != ODD_PARITY.
  - out_valid <= 1.
  - If the frame is in error and err_count is not all ones, err_count <= err_count + 1.
  - Go to OUT_HOLD.
- Latency: out_valid rises on the edge after the parity bit is accepted.
- State OUT_HOLD:
  - in_ready = 0.
  - out_data, out_parity_err and out_valid hold stable until out_ready = 1.
  - On that edge: out_valid <= 0, acc <= 0, shift register <= 0, go to RECV_DATA.
  - The next bit can be accepted one cycle after the output handshake; there is one bubble per frame, which is intentional.
- out_data keeps its last value after out_valid falls. Only the out_valid = 1 window is meaningful.
- err_count saturates at 2^ERR_CNT_W - 1 and never wraps.
- rst asserted mid-frame or in OUT_HOLD discards the partial or pending frame and restores all reset values on that edge. err_count is also cleared.
- An out_ready pulse while out_valid = 0 has no effect.
- Gaps in in_valid have no effect on state, counter or accumulator.

Test Plan:
- Defaults, back-to-back bits 1,0,1,0,0,1,0,1 then parity 0, out_ready = 1 → out_data = 0xA5, out_parity_err = 0, out_valid high for exactly 1 cycle, err_count = 0.
- Defaults, data 0x07 then parity 0 → out_parity_err = 1, err_count = 1. Then data 0x07 with parity 1 → out_parity_err = 0, err_count stays 1.
- Backpressure:
  - Stimulus: out_ready = 0 for 5 cycles after out_valid rises, while in_valid = 1 with random in_bit.
  - Response: in_ready = 0 throughout, out_data held at 0xA5. The next frame is decoded correctly after out_ready is raised.
- Reset mid-frame: assert rst for 1 cycle after 3 data bits, then send full frame 0x3C with parity 0 → out_data = 0x3C, out_parity_err = 0, err_count = 0.
- Saturation and odd parity:
  - Configuration: ODD_PARITY = 1, ERR_CNT_W = 2, FRAME_LEN = 1.
  - Stimulus: send 5 frames of data 1, parity 1.
  - Response: every frame flags an error, err_count reads 1, 2, 3, 3, 3.
- Sparse input: FRAME_LEN = 4, in_valid toggled every other cycle, data 0xB then parity 1 → out_data = 0xB, out_parity_err = 0.
